// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the dot-product sequencer.
// Holds the FSM state enum, static slice pin values and the default width.
package dsp_seq_pkg;

    localparam int DSP_DWIDTH = 8;

    // ay selected, ay and ax each through one input register
    localparam logic [7:0] DSP_MUXSEL_DOT = 8'h0B;

    // accumulator path on resulta
    localparam logic [1:0] DSP_FUNC_ACC = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        STREAM,
        DRAIN,
        OUT
    } seq_state_t;

endpackage

// File: rtl/dsp_slice.sv
// Behavioural multiply-accumulate slice used alongside the sequencer.
// Ports: clk, clr (sync clear), ay/az/ax/by/bz/bx operands, negate, sub,
//        loadconst, accumulate, constant, muxsel, func, scanin, chainin,
//        resulta (registered accumulator or product).
// Pipeline: input regs -> product reg -> accumulator -> output reg,
// four register stages in total.
module dsp_slice
    import dsp_seq_pkg::*;
#(
    parameter int DWIDTH = DSP_DWIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DWIDTH-1:0]     ay,
    input  logic [DWIDTH-1:0]     az,
    input  logic [DWIDTH-1:0]     ax,
    input  logic [DWIDTH-1:0]     by,
    input  logic [DWIDTH-1:0]     bz,
    input  logic [DWIDTH-1:0]     bx,
    input  logic                  negate,
    input  logic                  sub,
    input  logic                  loadconst,
    input  logic                  accumulate,
    input  logic [4*DWIDTH-1:0]   constant,
    input  logic [7:0]            muxsel,
    input  logic [1:0]            func,
    input  logic [2*DWIDTH-1:0]   scanin,
    input  logic [2*DWIDTH-1:0]   chainin,
    output logic [2*DWIDTH-1:0]   resulta
);

    localparam int PW = 2 * DWIDTH;

    logic [DWIDTH-1:0] a_in;
    logic [DWIDTH-1:0] a_r;
    logic [DWIDTH-1:0] a_op;
    logic [DWIDTH-1:0] b_r;
    logic [DWIDTH-1:0] b_op;
    logic              lc_r;
    logic              ac_r;
    logic              lc_p;
    logic              ac_p;
    logic [PW-1:0]     k_r;
    logic [PW-1:0]     k_p;
    logic [PW-1:0]     p_r;
    logic [PW-1:0]     acc;
    logic              unused_pins;

    // B-side and cascade pins are not modelled here
    assign unused_pins = ^{by, bz, bx, negate, sub, scanin, chainin,
                           constant[4*DWIDTH-1:PW], muxsel[7:4],
                           muxsel[2], func[0]};

    assign a_in = muxsel[1] ? ay : az;
    assign a_op = muxsel[0] ? a_r : a_in;
    assign b_op = muxsel[3] ? b_r : ax;

    always_ff @(posedge clk) begin
        if (clr) begin
            a_r     <= '0;
            b_r     <= '0;
            lc_r    <= 1'b0;
            ac_r    <= 1'b0;
            k_r     <= '0;
            p_r     <= '0;
            lc_p    <= 1'b0;
            ac_p    <= 1'b0;
            k_p     <= '0;
            acc     <= '0;
            resulta <= '0;
        end else begin
            a_r  <= a_in;
            b_r  <= ax;
            lc_r <= loadconst;
            ac_r <= accumulate;
            k_r  <= constant[PW-1:0];
            p_r  <= PW'(a_op) * PW'(b_op);
            lc_p <= lc_r;
            ac_p <= ac_r;
            k_p  <= k_r;
            if (lc_p) begin
                acc <= k_p;
            end else if (ac_p) begin
                acc <= acc + p_r;
            end else begin
                acc <= p_r;
            end
            resulta <= func[1] ? acc : p_r;
        end
    end

endmodule

// File: rtl/dsp_dot_sequencer.sv
// Operand/control sequencer driving one dsp_slice for unsigned dot products.
// Ports: clk, clr_n (async active-low); s_* operand stream (valid/ready/last);
//        cfg_bias seed; m_* result stream with length; dsp_* slice pins.
module dsp_dot_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int DWIDTH = DSP_DWIDTH,
    parameter int LAT    = 4,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DWIDTH-1:0]     s_a,
    input  logic [DWIDTH-1:0]     s_b,
    input  logic                  s_last,
    input  logic [2*DWIDTH-1:0]   cfg_bias,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*DWIDTH-1:0]   m_data,
    output logic [LEN_W-1:0]      m_len,
    output logic                  dsp_clr,
    output logic [DWIDTH-1:0]     dsp_ay,
    output logic [DWIDTH-1:0]     dsp_ax,
    output logic                  dsp_loadconst,
    output logic                  dsp_accumulate,
    output logic [4*DWIDTH-1:0]   dsp_constant,
    output logic [7:0]            dsp_muxsel,
    output logic [1:0]            dsp_func,
    input  logic [2*DWIDTH-1:0]   dsp_resulta
);

    localparam int DCW = $clog2(LAT + 1);

    seq_state_t       state;
    logic [LEN_W-1:0] cnt;
    logic [DCW-1:0]   dcnt;
    logic             s_fire;
    logic             seed_go;

    assign s_fire = s_valid && s_ready;

    // Both paths into SEED share one block of output updates below
    assign seed_go = (state == IDLE && !dsp_clr)
                  || (state == OUT && m_valid && m_ready);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state          <= IDLE;
            s_ready        <= 1'b0;
            m_valid        <= 1'b0;
            m_data         <= '0;
            m_len          <= '0;
            dsp_clr        <= 1'b1;
            dsp_ay         <= '0;
            dsp_ax         <= '0;
            dsp_loadconst  <= 1'b0;
            dsp_accumulate <= 1'b0;
            dsp_constant   <= '0;
            dsp_muxsel     <= '0;
            dsp_func       <= '0;
            cnt            <= '0;
            dcnt           <= '0;
        end else begin
            dsp_muxsel <= DSP_MUXSEL_DOT;
            dsp_func   <= DSP_FUNC_ACC;
            // zero operands unless a beat is taken: bubbles add nothing
            dsp_ay     <= '0;
            dsp_ax     <= '0;

            unique case (state)
                IDLE: begin
                    if (dsp_clr) begin
                        dsp_clr <= 1'b0;
                    end
                end
                SEED: begin
                    state          <= STREAM;
                    dsp_loadconst  <= 1'b0;
                    dsp_accumulate <= 1'b1;
                    s_ready        <= 1'b1;
                end
                STREAM: begin
                    if (s_fire) begin
                        dsp_ay <= s_a;
                        dsp_ax <= s_b;
                        if (cnt != '1) begin
                            cnt <= cnt + LEN_W'(1);
                        end
                        if (s_last) begin
                            state   <= DRAIN;
                            s_ready <= 1'b0;
                            dcnt    <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // last beat reaches resulta LAT edges after its handshake
                    if (dcnt == DCW'(LAT)) begin
                        m_data  <= dsp_resulta;
                        m_len   <= cnt;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (seed_go) begin
                state          <= SEED;
                dsp_loadconst  <= 1'b1;
                dsp_accumulate <= 1'b0;
                dsp_constant   <= {{(2*DWIDTH){1'b0}}, cfg_bias};
                s_ready        <= 1'b0;
                cnt            <= '0;
            end
        end
    end

endmodule

// File: doc/dsp_dot_sequencer.md
Name: dsp_dot_sequencer

Overview:
- Upstream operand and control sequencer for one `dsp_slice` instance, configured for 8-bit unsigned dot products.
- Accepts a stream of operand pairs (valid/ready, `last`-delimited) and drives the slice's inputs and control pins cycle by cycle.
- Seeds the slice accumulator with a bias, then captures the final `resulta` value once the pipeline has drained.
- Returns each result on a valid/ready output with the vector length.

Parameters:
- DWIDTH, 8: operand width; must match the slice.
- LAT, 4: slice latency in cycles, from its registered inputs to its output register.
- LEN_W, 8: width of the element counter `m_len`.

Ports:
- clk  in  1  clock
- clr_n  in  1  reset: asynchronous, active-low
- s_valid  in  1  operand beat valid
- s_ready  out  1  operand beat accepted when high together with `s_valid`
- s_a  in  DWIDTH  operand A
- s_b  in  DWIDTH  operand B
- s_last  in  1  marks the final beat of a vector
- cfg_bias  in  2*DWIDTH  bias, sampled in SEED
- m_valid  out  1  result valid
- m_ready  in  1  result consumed
- m_data  out  2*DWIDTH  dot product plus bias, mod 2^16
- m_len  out  LEN_W  beats in the vector; saturates at all-ones
- dsp_clr  out  1  slice synchronous clear
- dsp_ay  out  DWIDTH  slice ay
- dsp_ax  out  DWIDTH  slice ax
- dsp_loadconst  out  1  slice loadconst
- dsp_accumulate  out  1  slice accumulate
- dsp_constant  out  4*DWIDTH  slice constant
- dsp_muxsel  out  8  slice muxsel
- dsp_func  out  2  slice func
- dsp_resulta  in  2*DWIDTH  slice resulta

Behaviour:
- Static slice drives:
  - `dsp_muxsel` = 8'h0B (ay selected, ay and ax each through one input register, so data and control latency are aligned).
  - `dsp_func` = 2'b10 (accumulator path selected).
  - Slice az/by/bz/bx/negate/sub/scanin/chainin are tied to 0 at the parent.
- All `dsp_*` outputs, `s_ready`, `m_*` and `dsp_clr` come straight from flops.
- Reset (`clr_n` low, asynchronous):
  - state = IDLE; all outputs 0 except `dsp_clr` = 1.
  - `dsp_clr` falls on the first clk edge after `clr_n` rises.
  - Reset mid-vector discards all partial state; no result is emitted.
- FSM states: IDLE, SEED, STREAM, DRAIN, OUT.
  - IDLE → SEED on the first edge with `dsp_clr` = 0.
  - SEED (1 cycle): `dsp_loadconst` = 1, `dsp_accumulate` = 0, `dsp_constant` = {16'b0, `cfg_bias`}, `dsp_ay` = `dsp_ax` = 0, `s_ready` = 0, `m_len` counter = 0. Then → STREAM.
  - STREAM: `s_ready` = 1, `dsp_accumulate` = 1, `dsp_loadconst` = 0.
    - On handshake: drive `dsp_ay` = `s_a`, `dsp_ax` = `s_b`; counter +1 (saturating).
    - With no handshake: drive `dsp_ay` = `dsp_ax` = 0. This is a bubble and the accumulator is unchanged.
    - Handshake with `s_last` = 1 → DRAIN; `s_ready` is 0 from the next cycle.
  - DRAIN: `dsp_accumulate` = 1 with zero operands (holds the accumulator).
    - Lasts exactly LAT cycles after the last-beat handshake edge E0.
    - At edge E0+LAT+1, register `m_data` = `dsp_resulta`, `m_len` = counter, `m_valid` = 1, then → OUT.
  - OUT: zero operands, `accumulate` = 1.
    - `m_valid`, `m_data` and `m_len` stay stable until `m_valid` && `m_ready`.
    - On that handshake `m_valid` clears the same edge, → SEED.
- Single-beat vectors are legal; empty vectors are not representable.
- Arithmetic: unsigned; the slice wraps at 16 bits and `m_data` reports the wrapped value.
- Throughput: one vector of N beats with no bubbles takes N+LAT+3 cycles, plus any output stall.

Decomposition:
- Package `dsp_seq_pkg` holds:
  - the state enum;
  - `DSP_MUXSEL_DOT` = 8'h0B and `DSP_FUNC_ACC` = 2'b10;
  - the DWIDTH default.
- No sub-module; the FSM, the drain counter and the length counter live in one module.
- The bench instantiates `dsp_dot_sequencer` together with `dsp_slice`.

Test Plan:
- a={1,2,3}, b={4,5,6}, bias 0, no bubbles → `m_data` = 32, `m_len` = 3, `m_valid` rises LAT+1 cycles after the last handshake.
- bias 10, a={2}, b={3} (single beat) → `m_data` = 16, `m_len` = 1.
- Same vectors as scenario 1 with `s_valid` low for 1–3 random cycles between beats → `m_data` = 32, `m_len` = 3.
- a={255,255}, b={255,255}, bias 0 → `m_data` = 0xFC02 (130050 mod 65536).
- `m_ready` held low for 10 cycles → `m_valid`/`m_data`/`m_len` stable and `s_ready` = 0 throughout; the next vector {1}×{1}, bias 0 → 1.
- `clr_n` pulsed low mid-vector → all outputs 0 and `dsp_clr` = 1 immediately; no stale result appears; the next vector {3}×{7} → 21.
